// File: rtl/inst_fetch_buf_pkg.sv
// rtl/inst_fetch_buf_pkg.sv - shared defaults and helpers for the instruction fetch buffer
//
// Purpose: default bus widths, reset PC, PC increment and the counter-width
// helper shared by the fetch buffer top and its FIFO.
// Ports: none (package).

package inst_fetch_buf_pkg;

    localparam int unsigned INST_ADDR_W_DEF = 32;
    localparam int unsigned INST_DATA_W_DEF = 32;
    localparam int unsigned FETCH_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

    // Instructions are fixed 32-bit words, so the PC always advances by 4.
    localparam int unsigned PC_STEP = 4;

    // Counters must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// rtl/inst_fetch_buf_fetch_fifo.sv - instruction/PC FIFO with flush and combinational head
//
// Purpose: DEPTH-entry FIFO of {pc, instruction} words. The head is read
// combinationally from storage and forced to zero while empty.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   flush_i       empty the FIFO this cycle (wins over push and pop)
//   push_i        write data_i at the tail
//   data_i        entry to write
//   pop_i         remove the head entry (ignored when empty)
//   head_o        head entry, zero when empty
//   count_o       number of valid entries

module inst_fetch_buf_fetch_fifo
    import inst_fetch_buf_pkg::*;
#(
    parameter  int unsigned W     = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - instruction fetch front end with PC, request credit and buffer
//
// Purpose: owns the fetch PC, issues pipelined requests to instruction memory
// (req/gnt, in-order rvalid with variable latency), buffers returned words
// with their PCs and handles pipeline stall and branch redirect.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   rom_req_o, rom_addr_o      fetch request and address
//   rom_gnt_i                  request accepted this cycle
//   rom_rvalid_i, rom_rdata_i  in-order response
//   stall_i                    pipeline cannot take an instruction
//   redirect_i, redirect_pc_i  discard everything and refetch from new PC
//   inst_valid_o, inst_o, inst_pc_o  buffer head towards if_id

module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int unsigned       ADDR_W   = INST_ADDR_W_DEF,
    parameter int unsigned       DATA_W   = INST_DATA_W_DEF,
    parameter int unsigned       DEPTH    = FETCH_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [DATA_W-1:0] rom_rdata_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);

    localparam int unsigned       CNT_W = cnt_width(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]         fifo_count;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [CNT_W:0]           credit_used;
    logic                     issue;
    logic                     resp_accept;
    logic                     push;
    logic                     pop;

    // Every slot is either buffered or in flight, so the FIFO cannot overflow.
    // The request is also held low while rst is asserted.
    assign credit_used = {1'b0, fifo_count} + {1'b0, out_cnt_q};
    assign rom_req_o   = rst && !redirect_i && (credit_used < (CNT_W+1)'(DEPTH));
    assign rom_addr_o  = fetch_pc_q;
    assign issue       = rom_req_o && rom_gnt_i;

    // A response with nothing outstanding is outside the protocol; ignore it.
    assign resp_accept = rom_rvalid_i && (out_cnt_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (redirect_i) begin
            // Everything still in flight belongs to the old path, including a
            // response arriving right now, so all of it is discarded.
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            out_cnt_d  = out_cnt_q - CNT_W'(resp_accept);
            drop_cnt_d = out_cnt_q - CNT_W'(resp_accept);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            out_cnt_d = out_cnt_q + CNT_W'(issue) - CNT_W'(resp_accept);
            if (resp_accept) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + STEP;
                end
            end
            pop = (fifo_count != '0) && !stall_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    inst_fetch_buf_fetch_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  ({resp_pc_q, rom_rdata_i}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign inst_valid_o = (fifo_count != '0);
    assign inst_pc_o    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign inst_o       = fifo_head[DATA_W-1:0];

endmodule
